// File: rtl/spi_host_pkg.sv
// Shared definitions for the SPI host port: control-word field map,
// FSM encoding and default frame length.
package spi_host_pkg;

    localparam int FRAME_BITS_DFLT = 32;

    // spi_out field positions
    localparam int COMMIT_BIT = 32;
    localparam int ADDR_MSB   = 31;
    localparam int ADDR_LSB   = 16;
    localparam int WDATA_MSB  = 15;
    localparam int WDATA_LSB  = 8;
    localparam int RSVD_MSB   = 7;
    localparam int RSVD_LSB   = 4;
    localparam int WE_BIT     = 3;
    localparam int START_BIT  = 2;
    localparam int SYSRST_BIT = 1;
    localparam int CPURST_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_host_port_pin_sync.sv
// Multi-flop synchronizer for one SPI pin with rise/fall pulse detection
// taken from the last stage against one extra delayed copy.
module spi_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic spi_reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;

    // shift the pin into the chain; keep one delayed copy for edges
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        dly_d  = sync_q[SYNC_STAGES-1];
    end

    // synchronizer flops, reset to the pin's idle level
    always_ff @(posedge clk or negedge spi_reset) begin
        if (!spi_reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            dly_q  <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~dly_q;
    assign fall  = ~level & dly_q;

endmodule

// File: rtl/spi_host_port.sv
// Mode-0 SPI target front end for the debug bridge. All pins are
// oversampled in clk; frames are deserialized into the spi_out control
// word and spi_in status is serialized back on MISO.
module spi_host_port
    import spi_host_pkg::*;
#(
    parameter int         SYNC_STAGES      = 2,
    parameter int         FRAME_BITS       = FRAME_BITS_DFLT,
    parameter bit         AUTO_CLEAR_START = 1'b1,
    parameter logic [7:0] SIGNATURE        = 8'hA5
) (
    input  logic        clk,
    input  logic        spi_reset,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    input  logic [16:0] spi_in,
    output logic [32:0] spi_out,
    output logic        frame_err
);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_n_s, cs_rise, cs_fall;
    logic mosi_s;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
        .clk(clk), .spi_reset(spi_reset), .din(spi_sclk),
        .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
        .clk(clk), .spi_reset(spi_reset), .din(spi_cs_n),
        .level(cs_n_s), .rise(cs_rise), .fall(cs_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi (
        .clk(clk), .spi_reset(spi_reset), .din(spi_mosi),
        .level(mosi_s), .rise(), .fall()
    );

    spi_state_e  state_q, state_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [31:0] rx_shift_q, rx_shift_d;
    logic [31:0] tx_word_q, tx_word_d;
    logic [32:0] spi_out_q, spi_out_d;
    logic        miso_q, miso_d;
    logic        frame_err_q, frame_err_d;

    // frame FSM: next state, shift registers and control word update
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_word_d   = tx_word_q;
        miso_d      = miso_q;
        frame_err_d = 1'b0;
        spi_out_d   = spi_out_q;
        spi_out_d[COMMIT_BIT] = 1'b0;
        // start drops the cycle after commit so the bridge sees a fresh edge
        if (AUTO_CLEAR_START && spi_out_q[COMMIT_BIT])
            spi_out_d[START_BIT] = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                tx_word_d     = {spi_in[15:0], SIGNATURE, frame_cnt_q};
                tx_word_d[31] = spi_in[16] | spi_in[15];
                miso_d        = tx_word_d[31];
                bit_cnt_d     = 6'd0;
                state_d       = ST_SHIFT;
            end
            ST_SHIFT: begin
                // CS release takes priority over a coincident SCLK edge
                if (cs_rise) begin
                    if (bit_cnt_q == 6'(FRAME_BITS)) begin
                        state_d = ST_COMMIT;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end else if (cs_fall) begin
                    state_d = ST_LOAD;
                end else begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[30:0], mosi_s};
                        if (bit_cnt_q != 6'd63) bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                    if (sclk_fall) begin
                        tx_word_d = {tx_word_q[30:0], 1'b0};
                        miso_d    = tx_word_d[31];
                    end
                end
            end
            ST_COMMIT: begin
                spi_out_d[31:0]               = rx_shift_q;
                spi_out_d[RSVD_MSB:RSVD_LSB]  = '0;
                spi_out_d[COMMIT_BIT]         = 1'b1;
                frame_cnt_d                   = frame_cnt_q + 8'd1;
                state_d                       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge spi_reset) begin
        if (!spi_reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            rx_shift_q  <= '0;
            tx_word_q   <= '0;
            spi_out_q   <= '0;
            miso_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_word_q   <= tx_word_d;
            spi_out_q   <= spi_out_d;
            miso_q      <= miso_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign spi_out     = spi_out_q;
    assign spi_miso    = miso_q;
    assign spi_miso_oe = ~cs_n_s;
    assign frame_err   = frame_err_q;

endmodule
